// File: rtl/simt_divergence_stack.sv
// Per-warp reconvergence stack: sequences the warp active mask across divergent
// branches and issues fetch redirects when a path ends or the paths reconverge.
module simt_divergence_stack #(
  parameter int WARP_SIZE   = 32,
  parameter int PC_WIDTH    = 32,
  parameter int STACK_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           init_valid,
  input  logic [WARP_SIZE-1:0]           init_mask,
  input  logic                           branch_valid,
  input  logic                           branch_divergent,
  input  logic [WARP_SIZE-1:0]           branch_taken_mask,
  input  logic [WARP_SIZE-1:0]           branch_not_taken_mask,
  input  logic [PC_WIDTH-1:0]            branch_target_pc,
  input  logic [PC_WIDTH-1:0]            branch_fallthrough_pc,
  input  logic [PC_WIDTH-1:0]            branch_reconv_pc,
  input  logic                           pc_valid,
  input  logic [PC_WIDTH-1:0]            next_pc,
  output logic                           ready,
  output logic [WARP_SIZE-1:0]           active_mask,
  output logic                           redirect_valid,
  output logic [PC_WIDTH-1:0]            redirect_pc,
  output logic [$clog2(STACK_DEPTH):0]   stack_depth,
  output logic                           stack_overflow,
  output logic                           stack_underflow
);
  // state   | meaning
  // IDLE    | warp not started, inputs ignored
  // RUN     | accepting branch / pc inputs
  // RECHECK | one cycle after a pop: compare latched reconv PC with the new top

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);
  localparam logic PENDING = 1'b0;
  localparam logic RESTORE = 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, RECHECK} state_t;
  state_t state_q, state_d;

  logic [PC_WIDTH-1:0]  reconv_q       [STACK_DEPTH];
  logic [PC_WIDTH-1:0]  resume_pc_q    [STACK_DEPTH];
  logic [WARP_SIZE-1:0] resume_mask_q  [STACK_DEPTH];
  logic [WARP_SIZE-1:0] restore_mask_q [STACK_DEPTH];
  logic                 phase_q        [STACK_DEPTH];

  logic [DW-1:0]       depth_q;
  logic [PC_WIDTH-1:0] latched_pc_q;
  logic [AW-1:0]       top_idx, push_idx;
  logic                has_top, pc_match, latch_match;
  logic                do_push, do_ovf, do_pend, pop_req;

  assign top_idx     = AW'(depth_q - DW'(1));
  assign push_idx    = depth_q[AW-1:0];
  assign has_top     = (depth_q != '0);
  assign pc_match    = has_top && (reconv_q[top_idx] == next_pc);
  assign latch_match = has_top && (reconv_q[top_idx] == latched_pc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Action decode and next state; branch wins over pc when both arrive.
  always_comb begin
    state_d = state_q;
    do_push = 1'b0;
    do_ovf  = 1'b0;
    do_pend = 1'b0;
    pop_req = 1'b0;
    if (init_valid) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (branch_valid) begin
            if (branch_divergent) begin
              if (depth_q < FULL) do_push = 1'b1;
              else                do_ovf  = 1'b1;
            end
          end else if (pc_valid && pc_match) begin
            if (phase_q[top_idx] == RESTORE) pop_req = 1'b1;
            else                             do_pend = 1'b1;
          end
          if (pop_req && has_top) state_d = RECHECK;
        end
        RECHECK: begin
          state_d = RUN;
          if (latch_match) begin
            if (phase_q[top_idx] == RESTORE) begin
              pop_req = 1'b1;
              state_d = RECHECK;
            end else begin
              do_pend = 1'b1;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    ready = (state_q == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q         <= '0;
      active_mask     <= '0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
      latched_pc_q    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      if (init_valid) begin
        active_mask     <= init_mask;
        depth_q         <= '0;
        stack_overflow  <= 1'b0;
        stack_underflow <= 1'b0;
      end else if (do_push) begin
        depth_q        <= depth_q + DW'(1);
        active_mask    <= branch_taken_mask;
        redirect_valid <= 1'b1;
        redirect_pc    <= branch_target_pc;
      end else if (do_ovf) begin
        stack_overflow <= 1'b1;
      end else if (do_pend) begin
        active_mask    <= resume_mask_q[top_idx];
        redirect_valid <= 1'b1;
        redirect_pc    <= resume_pc_q[top_idx];
      end else if (pop_req) begin
        if (has_top) begin
          active_mask  <= restore_mask_q[top_idx];
          depth_q      <= depth_q - DW'(1);
          latched_pc_q <= reconv_q[top_idx];
        end else begin
          stack_underflow <= 1'b1;
        end
      end
    end
  end

  // Entry storage needs no reset: depth gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      reconv_q[push_idx]       <= branch_reconv_pc;
      resume_pc_q[push_idx]    <= branch_fallthrough_pc;
      resume_mask_q[push_idx]  <= branch_not_taken_mask;
      restore_mask_q[push_idx] <= active_mask;
      phase_q[push_idx]        <= PENDING;
    end else if (do_pend) begin
      phase_q[top_idx] <= RESTORE;
    end
  end

  assign stack_depth = depth_q;

endmodule
